arch_reg_file_mc: RTL and testbench
===================================

Name: arch_reg_file_mc

Overview:
Architectural register file for the multi-commit core. It accepts up to COMMIT_WIDTH ROB retirements per cycle, serves NUM_RD combinational read ports with optional same-cycle commit bypass, and holds x0 at zero. A dump engine streams every architectural value out over a valid/ready channel, one register per handshake, so rename/PRF state can be rebuilt after a flush.

Parameters:
NUM_AREGS, 32 (CORE_PKG value), number of architectural registers; must be a power of 2.
XLEN, 32, data width.
COMMIT_WIDTH, 2, number of ROB commit lanes; lane 0 is the oldest.
NUM_RD, 2, number of read ports.
RD_BYPASS, 1, 1 forwards same-cycle commit data to the read ports; 0 returns array contents only.

Ports:
clk  in  1  clock; the only clock.
rst  in  1  synchronous, active-high reset.
commit_valid  in  COMMIT_WIDTH  per-lane commit strobe.
commit_idx  in  COMMIT_WIDTH x AIDX  destination index per lane; AIDX = $clog2(NUM_AREGS).
commit_val  in  COMMIT_WIDTH x XLEN  write data per lane.
rd_idx  in  NUM_RD x AIDX  read index per port.
rd_data  out  NUM_RD x XLEN  read data per port.
dump_req  in  1  single-cycle request to start a dump.
dump_busy  out  1  dump engine is active.
dump_valid  out  1  dump beat is valid.
dump_ready  in  1  consumer accepts the beat.
dump_idx  out  AIDX  index of the current beat.
dump_val  out  XLEN  value of the current beat.
dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. On rst at a posedge, all registers clear to 0 and the FSM goes to IDLE. While in reset and in the cycle after, dump_busy, dump_valid and dump_done are 0 and dump_idx is 0. rst overrides any activity in the same cycle, including an in-progress dump, which is abandoned with no dump_done.
- Writes: at the posedge, each lane with commit_valid=1 and commit_idx!=0 writes its commit_val. Writes to index 0 are dropped.
- Same-index collision: if several lanes target one index, the highest-numbered (youngest) lane wins.
- Reads: rd_data is combinational from rd_idx. rd_idx=0 returns 0.
- Bypass (RD_BYPASS=1): if any valid lane this cycle matches a nonzero rd_idx, the youngest matching lane's commit_val is returned; otherwise the array value. With RD_BYPASS=0 the new value is visible in the cycle after the write.
- Dump FSM, states IDLE, DUMP, DONE:
  - IDLE -> DUMP on dump_req. The counter loads 0.
  - In DUMP: dump_busy=1 and dump_valid=1. dump_idx is the counter; dump_val is the array value at the counter, with no commit bypass. Index 0 is emitted as 0.
  - On dump_valid & dump_ready the counter increments. When the handshake occurs at counter=NUM_AREGS-1, the FSM moves to DONE.
  - dump_idx and dump_val stay stable while dump_ready=0.
  - DONE: dump_done=1 and dump_busy=1 for exactly one cycle, then IDLE.
  - dump_req in DUMP or DONE is ignored.
  - Exactly NUM_AREGS beats are emitted per dump.
- Commits during a dump are still written and never dropped. The ROB is expected to stall on dump_busy. A beat reflects the array state at its handshake cycle.
- The counter is AIDX+1 bits wide, so the terminal compare cannot wrap.

Decomposition:
- CORE_PKG holds NUM_AREGS, XLEN, COMMIT_WIDTH, the areg_idx_t typedef (logic [AIDX-1:0]), and the dump_state_e enum (IDLE, DUMP, DONE).
- One sub-module, arf_dump_ctrl, contains the FSM, counter and handshake, and outputs the dump index. The top level holds the array, the write-priority logic, and the read/bypass muxes.

Test Plan:
1. Reset, then read all indices -> all 0. Commit lane0 idx 5 val 0xDEADBEEF -> rd_idx=5 returns 0xDEADBEEF in the same cycle (RD_BYPASS=1) and in the next cycle from the array.
2. Same cycle: lane0 idx 7 val 0x11, lane1 idx 7 val 0x22 -> reg 7 = 0x22; bypass read of 7 also returns 0x22.
3. Commit idx 0 val 0xFFFFFFFF -> rd_idx=0 returns 0; dump beat 0 has val 0.
4. Preload reg i = i*4 for i=1..31. Pulse dump_req with dump_ready=1 -> 32 consecutive beats with idx 0..31 and val 0,4,...,124; dump_done pulses one cycle later; dump_busy falls with it.
5. Dump with dump_ready toggling 1/0 -> idx/val hold while ready=0; still exactly 32 beats. A second dump_req mid-dump -> no restart.
6. Assert rst at beat 10 of a dump -> next cycle dump_busy=0, dump_valid=0, no dump_done, reg 5 reads 0.

Source files
------------

// File: rtl/arch_reg_file_mc_pkg.sv
// Shared core constants, architectural index type and dump FSM state encoding.
package arch_reg_file_mc_pkg;

    localparam int CORE_NUM_AREGS    = 32;
    localparam int CORE_XLEN         = 32;
    localparam int CORE_COMMIT_WIDTH = 2;
    localparam int CORE_AIDX         = $clog2(CORE_NUM_AREGS);

    typedef logic [CORE_AIDX-1:0] areg_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        DUMP,
        DONE
    } dump_state_e;

endpackage

// File: rtl/arf_dump_ctrl.sv
// Dump sequencer: walks every architectural index once over a valid/ready channel.
// Index holds while ready is low; done pulses for one cycle after the final beat.
module arf_dump_ctrl
    import arch_reg_file_mc_pkg::*;
#(
    parameter  int NUM_AREGS = CORE_NUM_AREGS,
    localparam int AIDX      = $clog2(NUM_AREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dump_req_i,
    input  logic            dump_ready_i,
    output logic            dump_busy_o,
    output logic            dump_valid_o,
    output logic            dump_done_o,
    output logic [AIDX-1:0] dump_idx_o
);

    localparam int CNT_W = AIDX + 1;

    dump_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             valid_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (dump_req_i) begin
                        state_q <= DUMP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end
                DUMP: begin
                    if (dump_ready_i) begin
                        if (cnt_q == CNT_W'(NUM_AREGS - 1)) begin
                            state_q <= DONE;
                            cnt_q   <= '0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_busy_o  = busy_q;
    assign dump_valid_o = valid_q;
    assign dump_done_o  = done_q;
    assign dump_idx_o   = cnt_q[AIDX-1:0];

endmodule

// File: rtl/arch_reg_file_mc.sv
// Architectural register file: multi-lane commit (youngest lane wins), combinational
// read ports with optional commit bypass, x0 hard-wired to zero, and a dump stream.
module arch_reg_file_mc
    import arch_reg_file_mc_pkg::*;
#(
    parameter  int NUM_AREGS    = CORE_NUM_AREGS,
    parameter  int XLEN         = CORE_XLEN,
    parameter  int COMMIT_WIDTH = CORE_COMMIT_WIDTH,
    parameter  int NUM_RD       = 2,
    parameter  int RD_BYPASS    = 1,
    localparam int AIDX         = $clog2(NUM_AREGS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [COMMIT_WIDTH-1:0]           commit_valid,
    input  logic [COMMIT_WIDTH-1:0][AIDX-1:0] commit_idx,
    input  logic [COMMIT_WIDTH-1:0][XLEN-1:0] commit_val,
    input  logic [NUM_RD-1:0][AIDX-1:0]       rd_idx,
    output logic [NUM_RD-1:0][XLEN-1:0]       rd_data,
    input  logic                              dump_req,
    output logic                              dump_busy,
    output logic                              dump_valid,
    input  logic                              dump_ready,
    output logic [AIDX-1:0]                   dump_idx,
    output logic [XLEN-1:0]                   dump_val,
    output logic                              dump_done
);

    logic [XLEN-1:0] regs_q [NUM_AREGS];
    logic [XLEN-1:0] regs_d [NUM_AREGS];

    // Lanes applied oldest to youngest so the youngest overwrites on a collision.
    always_comb begin
        regs_d = regs_q;
        for (int l = 0; l < COMMIT_WIDTH; l++) begin
            if (commit_valid[l] && commit_idx[l] != '0) begin
                regs_d[commit_idx[l]] = commit_val[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_idx[p] != '0) begin
                rd_data[p] = regs_q[rd_idx[p]];
                if (RD_BYPASS != 0) begin
                    for (int l = 0; l < COMMIT_WIDTH; l++) begin
                        if (commit_valid[l] && commit_idx[l] == rd_idx[p]) begin
                            rd_data[p] = commit_val[l];
                        end
                    end
                end
            end
        end
    end

    arf_dump_ctrl #(
        .NUM_AREGS (NUM_AREGS)
    ) u_dump_ctrl (
        .clk          (clk),
        .rst          (rst),
        .dump_req_i   (dump_req),
        .dump_ready_i (dump_ready),
        .dump_busy_o  (dump_busy),
        .dump_valid_o (dump_valid),
        .dump_done_o  (dump_done),
        .dump_idx_o   (dump_idx)
    );

    // Dump beats read the array directly; in-flight commits land after the beat.
    assign dump_val = (dump_valid && dump_idx != '0) ? regs_q[dump_idx] : '0;

endmodule

// File: tb/tb_arch_reg_file_mc.sv
// Directed plus randomized bench for arch_reg_file_mc against a behavioural array model.
module tb_arch_reg_file_mc;
    import arch_reg_file_mc_pkg::*;

    localparam int NA = 32;
    localparam int XL = 32;
    localparam int CW = 2;
    localparam int NR = 2;
    localparam int AW = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [CW-1:0]         commit_valid;
    logic [CW-1:0][AW-1:0] commit_idx;
    logic [CW-1:0][XL-1:0] commit_val;
    logic [NR-1:0][AW-1:0] rd_idx;
    logic [NR-1:0][XL-1:0] rd_data;
    logic                  dump_req;
    logic                  dump_busy;
    logic                  dump_valid;
    logic                  dump_ready;
    logic [AW-1:0]         dump_idx;
    logic [XL-1:0]         dump_val;
    logic                  dump_done;

    int checks = 0;
    int errors = 0;
    logic [XL-1:0] mdl [NA];

    always #5 clk = ~clk;

    arch_reg_file_mc #(
        .NUM_AREGS    (NA),
        .XLEN         (XL),
        .COMMIT_WIDTH (CW),
        .NUM_RD       (NR),
        .RD_BYPASS    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .commit_idx   (commit_idx),
        .commit_val   (commit_val),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .dump_req     (dump_req),
        .dump_busy    (dump_busy),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_idx     (dump_idx),
        .dump_val     (dump_val),
        .dump_done    (dump_done)
    );

    task automatic check(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Youngest valid lane hitting a nonzero index supplies the value; else the stored one.
    function automatic logic [XL-1:0] ref_read(input areg_idx_t idx);
        if (idx == 0) return '0;
        for (int l = CW - 1; l >= 0; l--) begin
            if (commit_valid[l] && commit_idx[l] == idx) return commit_val[l];
        end
        return mdl[idx];
    endfunction

    task automatic model_commit();
        bit written [NA];
        for (int i = 0; i < NA; i++) written[i] = 1'b0;
        for (int l = CW - 1; l >= 0; l--) begin
            if (commit_valid[l] && commit_idx[l] != 0 && !written[commit_idx[l]]) begin
                mdl[commit_idx[l]] = commit_val[l];
                written[commit_idx[l]] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NA; i++) mdl[i] = '0;
        end else begin
            model_commit();
        end
        #1;
    endtask

    task automatic check_reads(input string tag);
        for (int p = 0; p < NR; p++) check(tag, rd_data[p], ref_read(rd_idx[p]));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, {31'd0, dump_busy}, 32'd0);
        check({tag, "_valid"}, {31'd0, dump_valid}, 32'd0);
        check({tag, "_done"}, {31'd0, dump_done}, 32'd0);
        check({tag, "_idx"}, {27'd0, dump_idx}, 32'd0);
    endtask

    // mode 0: ready always high, 1: ready toggles with a stray dump_req, 2: random ready and commits
    task automatic run_dump(input int mode, input int abort_at, input bit expect_x4);
        int beat;
        int cyc;
        dump_req = 1'b1;
        dump_ready = 1'b0;
        #1;
        tick();
        dump_req = 1'b0;
        beat = 0;
        cyc = 0;
        while (beat < NA && cyc < 400) begin
            if (abort_at >= 0 && beat == abort_at) break;
            case (mode)
                0: dump_ready = 1'b1;
                1: dump_ready = (cyc % 2 == 0);
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
            dump_req = (mode == 1 && cyc == 7);
            if (mode == 2) begin
                for (int l = 0; l < CW; l++) begin
                    commit_valid[l] = 1'($urandom_range(0, 1));
                    commit_idx[l] = AW'($urandom_range(0, NA - 1));
                    commit_val[l] = $urandom;
                end
                for (int p = 0; p < NR; p++) rd_idx[p] = AW'($urandom_range(0, NA - 1));
            end
            #1;
            check("dump_busy", {31'd0, dump_busy}, 32'd1);
            check("dump_valid", {31'd0, dump_valid}, 32'd1);
            check("dump_idx", {27'd0, dump_idx}, beat);
            check("dump_val", dump_val, (beat == 0) ? '0 : mdl[beat]);
            if (expect_x4) check("dump_val_x4", dump_val, beat * 4);
            if (mode == 2) check_reads("rd_during_dump");
            tick();
            if (dump_ready) beat++;
            cyc++;
        end
        commit_valid = '0;
        dump_req = 1'b0;
        if (abort_at < 0) begin
            check("dump_beats", beat, NA);
            dump_ready = (mode == 1) ? 1'b0 : 1'b1;
            dump_req = (mode == 1);
            #1;
            check("done_pulse", {31'd0, dump_done}, 32'd1);
            check("done_busy", {31'd0, dump_busy}, 32'd1);
            check("done_valid", {31'd0, dump_valid}, 32'd0);
            tick();
            dump_req = 1'b0;
            #1;
            check_quiet("after_done");
            tick();
            #1;
            check_quiet("idle_after_done");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        commit_valid = '0;
        commit_idx = '0;
        commit_val = '0;
        rd_idx = '0;
        dump_req = 1'b0;
        dump_ready = 1'b0;
        tick();
        tick();
        check_quiet("in_reset");
        rst = 1'b0;
        tick();
        check_quiet("post_reset");

        // Test 1: all zero after reset, then bypass and stored read of reg 5
        for (int i = 0; i < NA; i++) begin
            rd_idx[0] = AW'(i);
            rd_idx[1] = AW'(NA - 1 - i);
            #1;
            check("reset_read0", rd_data[0], '0);
            check("reset_read1", rd_data[1], '0);
        end
        commit_valid = 2'b01;
        commit_idx[0] = 5'd5;
        commit_val[0] = 32'hDEADBEEF;
        rd_idx[0] = 5'd5;
        #1;
        check("bypass_5", rd_data[0], 32'hDEADBEEF);
        tick();
        commit_valid = '0;
        #1;
        check("array_5", rd_data[0], 32'hDEADBEEF);

        // Test 2: collision, youngest lane wins
        commit_valid = 2'b11;
        commit_idx[0] = 5'd7;
        commit_val[0] = 32'h11;
        commit_idx[1] = 5'd7;
        commit_val[1] = 32'h22;
        rd_idx[1] = 5'd7;
        #1;
        check("bypass_collide", rd_data[1], 32'h22);
        tick();
        commit_valid = '0;
        #1;
        check("array_collide", rd_data[1], 32'h22);

        // Test 3: writes to x0 are dropped
        commit_valid = 2'b11;
        commit_idx[0] = 5'd0;
        commit_val[0] = 32'hFFFFFFFF;
        commit_idx[1] = 5'd0;
        commit_val[1] = 32'hFFFFFFFF;
        rd_idx[0] = 5'd0;
        #1;
        check("x0_bypass", rd_data[0], '0);
        tick();
        commit_valid = '0;
        #1;
        check("x0_array", rd_data[0], '0);

        // Random commit/read traffic against the model
        for (int c = 0; c < 150; c++) begin
            for (int l = 0; l < CW; l++) begin
                commit_valid[l] = 1'($urandom_range(0, 1));
                commit_idx[l] = AW'($urandom_range(0, NA - 1));
                commit_val[l] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) commit_idx[1] = commit_idx[0];
            for (int p = 0; p < NR; p++) begin
                rd_idx[p] = ($urandom_range(0, 1) == 0) ? commit_idx[p % CW]
                                                         : AW'($urandom_range(0, NA - 1));
            end
            #1;
            check_reads("rand_read");
            tick();
        end
        commit_valid = '0;

        // Test 4: preload i*4 and dump at full rate
        for (int i = 1; i < NA; i += 2) begin
            commit_valid = 2'b01;
            commit_idx[0] = AW'(i);
            commit_val[0] = i * 4;
            if (i + 1 < NA) begin
                commit_valid[1] = 1'b1;
                commit_idx[1] = AW'(i + 1);
                commit_val[1] = (i + 1) * 4;
            end
            #1;
            tick();
        end
        commit_valid = '0;
        run_dump(0, -1, 1'b1);

        // Test 5: toggling ready with a stray request mid-dump
        run_dump(1, -1, 1'b1);

        // Random ready and live commits during a dump
        run_dump(2, -1, 1'b0);

        // Test 6: reset abandons a dump at beat 10
        run_dump(0, 10, 1'b0);
        rst = 1'b1;
        rd_idx[0] = 5'd5;
        tick();
        #1;
        check_quiet("abort_in_reset");
        check("abort_reg5", rd_data[0], '0);
        rst = 1'b0;
        tick();
        #1;
        check_quiet("abort_after");
        tick();
        #1;
        check("abort_no_done", {31'd0, dump_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
